// File: rtl/fifo_read_drain_if.sv
// -----------------------------------------------------------------------------
// fifo_read_drain_if
// Groups the two buses around the read-side drain.
//   FIFO read port : rd_en (pop request), rd_data, rd_empty
//   Output stream  : m_valid, m_ready, m_data
// Handshake: a word moves downstream on every rising edge where m_valid and
// m_ready are both 1. Once m_valid is 1, m_data stays fixed until that edge.
// A FIFO pop happens on every rising edge where rd_en=1 and rd_empty=0; the
// popped word is on rd_data for the whole following cycle.
// Modports:
//   master : the drain itself (drives rd_en and the stream outputs)
//   slave  : the environment (FIFO plus downstream consumer)
// -----------------------------------------------------------------------------
interface fifo_read_drain_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_empty;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (
    output rd_en,
    input  rd_data,
    input  rd_empty,
    output m_valid,
    input  m_ready,
    output m_data
  );

  modport slave (
    input  rd_en,
    output rd_data,
    output rd_empty,
    input  m_valid,
    output m_ready,
    input  m_data
  );
endinterface

// File: rtl/fifo_read_drain.sv
// -----------------------------------------------------------------------------
// fifo_read_drain
// Pops words from a FIFO read port with one-cycle registered read latency and
// presents them on a valid/ready stream through a 2-entry skid buffer, at one
// word per cycle when downstream is always ready. Counts delivered words.
// Ports:
//   clk         read-domain clock, rising edge
//   rst         synchronous, active-high reset
//   bus         fifo_read_drain_if.master (FIFO read port + output stream)
//   word_count  handshakes completed since reset, wraps modulo 2^CNT_WIDTH
//   idle        buffer empty, no read in flight, and FIFO reports empty
//   dbg_occ     buffer occupancy state (0/1/2) for observation
// -----------------------------------------------------------------------------
module fifo_read_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_read_drain_if.master    bus,
  output logic [CNT_WIDTH-1:0] word_count,
  output logic                 idle,
  output logic [1:0]           dbg_occ
);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  occ_e                  occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic                  head_q, head_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [DATA_WIDTH-1:0] buf_q [2];

  logic       pop;
  logic       capture;
  logic       tail;
  logic [1:0] level;

  assign pop     = (occ_q != OCC_EMPTY) && bus.m_ready;
  assign capture = inflight_q;

  // Occupancy after this edge before any new request. Using pop here lets a
  // new read issue at occ=1/inflight=1 while downstream drains, which is what
  // keeps one word per cycle. Max value 3 fits; pop implies occ>=1.
  assign level = 2'(occ_q) + {1'b0, inflight_q} - {1'b0, pop};

  assign bus.rd_en = !rst && !bus.rd_empty && (level < 2'd2);

  // A read is only in flight when occ<=1, so the tail slot is head+occ
  // and never collides with the head entry still being presented.
  assign tail = head_q ^ occ_q[0];

  always_comb begin
    occ_d      = occ_q;
    inflight_d = bus.rd_en;
    head_d     = head_q ^ pop;
    count_d    = count_q + CNT_WIDTH'(pop);
    unique case (occ_q)
      OCC_EMPTY: if (capture)          occ_d = OCC_ONE;
      OCC_ONE: begin
        if (capture && !pop)           occ_d = OCC_TWO;
        else if (!capture && pop)      occ_d = OCC_EMPTY;
      end
      OCC_TWO:   if (pop && !capture)  occ_d = OCC_ONE;
      default:                         occ_d = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q      <= OCC_EMPTY;
      inflight_q <= 1'b0;
      head_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      count_q    <= count_d;
      // The popped word lands regardless of what rd_empty says this cycle.
      if (capture) buf_q[tail] <= bus.rd_data;
    end
  end

  assign bus.m_valid = (occ_q != OCC_EMPTY);
  assign bus.m_data  = buf_q[head_q];
  assign word_count  = count_q;
  assign idle        = (occ_q == OCC_EMPTY) && !inflight_q && bus.rd_empty;
  assign dbg_occ     = occ_q;

endmodule

// File: tb/tb_fifo_read_drain.sv
module tb_fifo_read_drain;
  localparam int DW   = 8;
  localparam int CW   = 16;
  localparam int CW_S = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_read_drain_if #(.DATA_WIDTH(DW)) bus0 ();
  fifo_read_drain_if #(.DATA_WIDTH(DW)) bus1 ();

  logic [CW-1:0]   wc0;
  logic [CW_S-1:0] wc1;
  logic            idle0, idle1;
  logic [1:0]      occ0, occ1;

  fifo_read_drain #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0),
    .word_count(wc0), .idle(idle0), .dbg_occ(occ0)
  );

  // Narrow-counter copy fed the same inputs, to observe counter wrap.
  fifo_read_drain #(.DATA_WIDTH(DW), .CNT_WIDTH(CW_S)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .word_count(wc1), .idle(idle1), .dbg_occ(occ1)
  );

  assign bus1.rd_data  = bus0.rd_data;
  assign bus1.rd_empty = bus0.rd_empty;
  assign bus1.m_ready  = bus0.m_ready;

  // ---------------- reference model state ----------------
  logic [DW-1:0] src_q[$];   // contents of the modelled FIFO
  logic [DW-1:0] exp_q[$];   // words captured, awaiting delivery, in order
  bit            flight;     // a popped word is on its way
  logic [DW-1:0] rd_word;    // value the FIFO shows on rd_data
  int unsigned   model_cnt;
  int            n_cmp;
  int            n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic cycle(input bit ready, input bit r);
    bit exp_valid, exp_pop, exp_rd_en, empty;
    int lvl;
    @(negedge clk);
    rst           = r;
    empty         = (src_q.size() == 0);
    bus0.m_ready  = ready;
    bus0.rd_empty = empty;
    bus0.rd_data  = rd_word;
    #1;
    exp_valid = (exp_q.size() != 0);
    exp_pop   = exp_valid && ready;
    lvl       = exp_q.size() + int'(flight) - int'(exp_pop);
    exp_rd_en = !r && !empty && (lvl < 2);
    check("rd_en",      32'(bus0.rd_en),   32'(exp_rd_en));
    check("m_valid",    32'(bus0.m_valid), 32'(exp_valid));
    if (exp_valid) check("m_data", 32'(bus0.m_data), 32'(exp_q[0]));
    check("word_count", 32'(wc0),          model_cnt % (1 << CW));
    check("word_count_w4", 32'(wc1),       model_cnt % (1 << CW_S));
    check("idle",       32'(idle0),        32'(exp_q.size() == 0 && !flight && empty));
    check("occ",        32'(occ0),         32'(exp_q.size()));
    @(posedge clk);
    if (r) begin
      exp_q.delete();
      flight    = 1'b0;
      model_cnt = 0;
    end else begin
      if (exp_pop) begin
        void'(exp_q.pop_front());
        model_cnt++;
      end
      if (flight) exp_q.push_back(rd_word);
      flight = exp_rd_en;
      if (exp_rd_en) rd_word = src_q.pop_front();
    end
  endtask

  function automatic bit model_idle();
    return (src_q.size() == 0) && (exp_q.size() == 0) && !flight;
  endfunction

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && !model_idle(); i++) cycle(1'b1, 1'b0);
    check("drain_timeout", 32'(model_idle()), 32'd1);
  endtask

  task automatic push_range(input int first, input int n);
    for (int i = 0; i < n; i++) src_q.push_back(DW'(first + i));
  endtask

  // Settle-and-sample point for explicit checks between cycles.
  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp = 0; n_fail = 0; model_cnt = 0; flight = 1'b0; rd_word = '0;
    rst = 1'b1;
    bus0.m_ready = 1'b0; bus0.rd_empty = 1'b1; bus0.rd_data = '0;

    // Reset held 3 cycles with data waiting: no pops, nothing valid.
    push_range(8'h00, 16);
    repeat (3) cycle(1'b1, 1'b1);

    // Streaming 0x00..0x0F.
    drain(60);
    settle();
    check("stream_count", 32'(wc0),   32'd16);
    check("stream_wrap",  32'(wc1),   32'd0);
    check("stream_idle",  32'(idle0), 32'd1);

    // Backpressure mid-stream.
    push_range(8'h10, 16);
    repeat (4) cycle(1'b1, 1'b0);
    repeat (5) cycle(1'b0, 1'b0);
    drain(60);
    settle();
    check("bp_count", 32'(wc0), 32'd32);

    // Drain edge: a single word held under backpressure.
    cycle(1'b1, 1'b1);
    src_q.push_back(8'hA5);
    repeat (4) cycle(1'b0, 1'b0);
    settle();
    check("edge_valid", 32'(bus0.m_valid), 32'd1);
    check("edge_data",  32'(bus0.m_data),  32'hA5);
    check("edge_rd_en", 32'(bus0.rd_en),   32'd0);
    drain(10);
    settle();
    check("edge_count", 32'(wc0),   32'd1);
    check("edge_idle",  32'(idle0), 32'd1);

    // Counter wrap on the 4-bit copy: 1 + 17 words -> 2.
    push_range(8'h40, 17);
    drain(60);
    settle();
    check("wrap_count_w4", 32'(wc1), 32'd2);
    check("wrap_count",    32'(wc0), 32'd18);

    // Random traffic: sporadic FIFO fill, random backpressure.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0 && src_q.size() < 20) src_q.push_back(DW'($urandom));
      cycle($urandom_range(0, 3) != 0, 1'b0);
    end
    drain(100);

    // Reset in steady streaming: in-flight and buffered words are discarded.
    cycle(1'b1, 1'b1);
    push_range(8'h80, 10);
    repeat (4) cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    settle();
    check("rst_mid_valid", 32'(bus0.m_valid), 32'd0);
    check("rst_mid_count", 32'(wc0),          32'd0);
    drain(60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end
endmodule
